// File: rtl/ram_store_ctrl.sv
// Store-side RAM controller: word writes direct, sub-word writes by read-modify-write.
// Latency: done 1 cycle after handshake for word stores, 3 cycles for byte/halfword RMW.
// Backpressure: req_ready drops for the whole store; requests offered while busy are ignored.
// Build option STORE_BYTE_ENABLE_EN: RAM has byte write enables, so sub-word stores skip RMW.
module ram_store_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [1:0]        req_mask,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd_en,
   input  logic [31:0]       ram_rd_data,
   output logic              ram_wr_en,
   output logic [31:0]       ram_wr_data,
   output logic [3:0]        ram_be,
   output logic              done,
   output logic              misaligned
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_MERGE,
      S_WRITE,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        mask_q, mask_d;
   logic              req_ready_q, req_ready_d;
   logic              rd_en_q, rd_en_d;
   logic              wr_en_q, wr_en_d;
   logic              done_q, done_d;
   logic              mis_q, mis_d;
   logic [3:0]        be_q, be_d;
   // ram_wr_data_q doubles as the merge register for read-modify-write
   logic [31:0]       wr_data_q, wr_data_d;

   logic req_word;
   logic req_half;
   logic req_bad;

`ifndef STORE_BYTE_ENABLE_EN
   logic [15:0] data_lo_q, data_lo_d;
   logic [31:0] merged;
`else
   logic        unused_be_build;
   assign unused_be_build = ^{ram_rd_data, addr_q[1:0], mask_q};
`endif

   // Size decode and alignment check of the offered request
   always_comb begin
      req_word = req_mask[1];
      req_half = (req_mask == 2'b01);
      req_bad  = (req_word && (req_addr[1:0] != 2'b00)) || (req_half && req_addr[0]);
   end

`ifndef STORE_BYTE_ENABLE_EN
   // Replace one byte or halfword lane of the word just read (little-endian lanes)
   always_comb begin
      merged = ram_rd_data;
      if (mask_q == 2'b01) begin
         if (addr_q[1]) merged[31:16] = data_lo_q;
         else           merged[15:0]  = data_lo_q;
      end else begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = data_lo_q[7:0];
            2'd1:    merged[15:8]  = data_lo_q[7:0];
            2'd2:    merged[23:16] = data_lo_q[7:0];
            default: merged[31:24] = data_lo_q[7:0];
         endcase
      end
   end
`endif

   // Next-state and next-output decode; outputs are registered for the state being entered
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      mask_d      = mask_q;
      wr_data_d   = wr_data_q;
      req_ready_d = 1'b0;
      rd_en_d     = 1'b0;
      wr_en_d     = 1'b0;
      done_d      = 1'b0;
      mis_d       = 1'b0;
      be_d        = 4'b0000;
`ifndef STORE_BYTE_ENABLE_EN
      data_lo_d   = data_lo_q;
`endif
      case (state_q)
         S_IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid) begin
               req_ready_d = 1'b0;
               addr_d      = req_addr;
               mask_d      = req_mask;
`ifndef STORE_BYTE_ENABLE_EN
               data_lo_d   = req_data[15:0];
`endif
               if (req_bad) begin
                  state_d = S_ERR;
                  mis_d   = 1'b1;
               end else if (req_word) begin
                  state_d   = S_WRITE;
                  wr_en_d   = 1'b1;
                  done_d    = 1'b1;
                  be_d      = 4'b1111;
                  wr_data_d = req_data;
               end else begin
`ifdef STORE_BYTE_ENABLE_EN
                  state_d   = S_WRITE;
                  wr_en_d   = 1'b1;
                  done_d    = 1'b1;
                  be_d      = req_half ? (req_addr[1] ? 4'b1100 : 4'b0011)
                                       : (4'b0001 << req_addr[1:0]);
                  wr_data_d = req_half ? {2{req_data[15:0]}} : {4{req_data[7:0]}};
`else
                  state_d   = S_READ;
                  rd_en_d   = 1'b1;
`endif
               end
            end
         end
         S_READ: begin
`ifdef STORE_BYTE_ENABLE_EN
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
`else
            // read data arrives during MERGE
            state_d = S_MERGE;
`endif
         end
         S_MERGE: begin
`ifdef STORE_BYTE_ENABLE_EN
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
`else
            state_d   = S_WRITE;
            wr_en_d   = 1'b1;
            done_d    = 1'b1;
            be_d      = 4'b1111;
            wr_data_d = merged;
`endif
         end
         S_WRITE, S_ERR: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   // State, latched request and registered outputs; reset drops any in-flight store
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         mask_q      <= 2'b00;
         req_ready_q <= 1'b1;
         rd_en_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         done_q      <= 1'b0;
         mis_q       <= 1'b0;
         be_q        <= 4'b0000;
         wr_data_q   <= 32'h0;
`ifndef STORE_BYTE_ENABLE_EN
         data_lo_q   <= 16'h0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         mask_q      <= mask_d;
         req_ready_q <= req_ready_d;
         rd_en_q     <= rd_en_d;
         wr_en_q     <= wr_en_d;
         done_q      <= done_d;
         mis_q       <= mis_d;
         be_q        <= be_d;
         wr_data_q   <= wr_data_d;
`ifndef STORE_BYTE_ENABLE_EN
         data_lo_q   <= data_lo_d;
`endif
      end
   end

   assign req_ready   = req_ready_q;
   assign ram_addr    = {addr_q[ADDR_W-1:2], 2'b00};
   assign ram_rd_en   = rd_en_q;
   assign ram_wr_en   = wr_en_q;
   assign ram_wr_data = wr_data_q;
   assign ram_be      = be_q;
   assign done        = done_q;
   assign misaligned  = mis_q;

endmodule

// File: tb/tb_ram_store_ctrl.sv
// Bench for ram_store_ctrl: directed store scenarios then random stores against a word-array model.
module tb_ram_store_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_data = 32'h0;
   logic [1:0]  req_mask = 2'b00;
   logic [31:0] ram_addr;
   logic        ram_rd_en;
   logic [31:0] ram_rd_data = 32'h0;
   logic        ram_wr_en;
   logic [31:0] ram_wr_data;
   logic [3:0]  ram_be;
   logic        done;
   logic        misaligned;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef STORE_BYTE_ENABLE_EN
   localparam bit BE_BUILD = 1'b1;
`else
   localparam bit BE_BUILD = 1'b0;
`endif

   logic [31:0] ram_mem [bit [31:0]];
   logic [31:0] ref_mem [bit [31:0]];

   ram_store_ctrl #(.ADDR_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_mask   (req_mask),
      .ram_addr   (ram_addr),
      .ram_rd_en  (ram_rd_en),
      .ram_rd_data(ram_rd_data),
      .ram_wr_en  (ram_wr_en),
      .ram_wr_data(ram_wr_data),
      .ram_be     (ram_be),
      .done       (done),
      .misaligned (misaligned)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   // Synchronous RAM, one-cycle read latency, per-byte write enables
   always @(posedge clk) begin
      logic [31:0] w;
      if (ram_rd_en) ram_rd_data <= ram_word(ram_addr);
      if (ram_wr_en) begin
         w = ram_word(ram_addr);
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) w[8*b +: 8] = ram_wr_data[8*b +: 8];
         ram_mem[ram_addr] = w;
      end
   end

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] w);
      ram_mem[a] = w;
      ref_mem[a] = w;
   endtask

   // One store, called at a negedge with the DUT idle; returns at the negedge where it is idle again.
   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m, input bit hold);
      logic [31:0] wa, old_w, new_w, lane_mask, exp_wd;
      logic [3:0]  exp_be;
      bit          word, half, mis, rmw, wr_cycle;
      int          sh, lat;
      word  = m[1];
      half  = (m == 2'b01);
      mis   = (word && a[1:0] != 2'b00) || (half && a[0]);
      wa    = {a[31:2], 2'b00};
      old_w = ref_word(wa);
      if (word) begin
         new_w  = d;
         exp_be = 4'hF;
      end else begin
         sh        = half ? 16 * int'(a[1]) : 8 * int'(a[1:0]);
         lane_mask = (half ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
         new_w     = (old_w & ~lane_mask) | ((d << sh) & lane_mask);
         exp_be    = half ? (4'b0011 << (sh / 8)) : (4'b0001 << (sh / 8));
      end
      if (BE_BUILD) exp_wd = word ? d : (half ? {2{d[15:0]}} : {4{d[7:0]}});
      else begin
         exp_wd = new_w;
         exp_be = 4'hF;
      end
      rmw = !BE_BUILD && !word && !mis;
      lat = rmw ? 3 : 1;

      check1("ready_before_req", req_ready, 1'b1);
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      req_mask  = m;
      @(negedge clk);
      for (int c = 1; c <= lat; c++) begin
         wr_cycle = (c == lat) && !mis;
         check1("ready_busy", req_ready, 1'b0);
         check1("rd_en", ram_rd_en, (c == 1) && rmw);
         check1("wr_en", ram_wr_en, wr_cycle);
         check1("done", done, wr_cycle);
         check1("misaligned", misaligned, mis && (c == 1));
         check32("be", 32'(ram_be), wr_cycle ? 32'(exp_be) : 32'h0);
         check32("ram_addr", ram_addr, wa);
         if (wr_cycle) check32("wr_data", ram_wr_data, exp_wd);
         req_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
         req_addr  = $urandom;
         req_data  = $urandom;
         req_mask  = 2'($urandom_range(0, 3));
         @(negedge clk);
      end
      if (!mis) ref_mem[wa] = new_w;
      check1("ready_after", req_ready, 1'b1);
      check1("wr_en_after", ram_wr_en, 1'b0);
      check1("done_after", done, 1'b0);
      check32("ram_content", ram_word(wa), ref_word(wa));
      req_valid = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      check1("rst_ready", req_ready, 1'b1);
      check1("rst_rd_en", ram_rd_en, 1'b0);
      check1("rst_wr_en", ram_wr_en, 1'b0);
      check1("rst_done", done, 1'b0);
      check1("rst_mis", misaligned, 1'b0);
      check32("rst_addr", ram_addr, 32'h0);
      check32("rst_wdata", ram_wr_data, 32'h0);
      check32("rst_be", 32'(ram_be), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // word store
      preload(32'h100, 32'h1122_3344);
      store(32'h100, 32'hDEAD_BEEF, 2'b10, 1'b0);
      check32("tp_word_mem", ram_word(32'h100), 32'hDEAD_BEEF);

      // byte store to lane 3
      preload(32'h100, 32'h1122_3344);
      store(32'h103, 32'h0000_00AB, 2'b00, 1'b0);
      check32("tp_byte_mem", ram_word(32'h100), 32'hAB22_3344);

      // halfword store with a request held through the busy cycles
      preload(32'h100, 32'h1122_3344);
      store(32'h102, 32'h1234_CAFE, 2'b01, 1'b1);
      store(32'h104, 32'h0BAD_F00D, 2'b10, 1'b0);
      check32("tp_half_mem", ram_word(32'h100), 32'hCAFE_3344);
      check32("tp_b2b_mem", ram_word(32'h104), 32'h0BAD_F00D);

      // misaligned halfword and word
      store(32'h101, 32'hFFFF_FFFF, 2'b01, 1'b0);
      store(32'h102, 32'hFFFF_FFFF, 2'b10, 1'b0);
      check32("tp_mis_mem", ram_word(32'h100), 32'hCAFE_3344);

      // byte to lane 1
      store(32'h101, 32'h0000_0055, 2'b00, 1'b0);
      check32("tp_lane1_mem", ram_word(32'h100), 32'hCAFE_5544);

`ifndef STORE_BYTE_ENABLE_EN
      // reset while in MERGE drops the store
      preload(32'h100, 32'h1122_3344);
      req_valid = 1'b1;
      req_addr  = 32'h100;
      req_data  = 32'h0000_0077;
      req_mask  = 2'b00;
      @(negedge clk);
      req_valid = 1'b0;
      check1("mid_rd_en", ram_rd_en, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check1("mid_rst_rd_en", ram_rd_en, 1'b0);
      check1("mid_rst_wr_en", ram_wr_en, 1'b0);
      check1("mid_rst_done", done, 1'b0);
      check1("mid_rst_ready", req_ready, 1'b1);
      check32("mid_rst_be", 32'(ram_be), 32'h0);
      repeat (2) @(negedge clk);
      check1("mid_rst_no_wr", ram_wr_en, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check32("mid_rst_mem", ram_word(32'h100), 32'h1122_3344);
      store(32'h200, 32'h600D_CAFE, 2'b11, 1'b0);
      check32("post_rst_mem", ram_word(32'h200), 32'h600D_CAFE);
`endif

      // random stores over a small address window
      for (int i = 0; i < 300; i++) begin
         store(32'($urandom_range(0, 255)), $urandom, 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
      end
      for (int w = 0; w < 256; w += 4)
         check32("final_mem", ram_word(32'(w)), ref_word(32'(w)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_store_ctrl.md
# ram_store_ctrl

Store-side RAM access controller for the multi-cycle datapath: the write-direction counterpart of the load data extractor. Takes a store request (byte address, register data, size mask) and performs the RAM write. Word stores write directly. Byte and halfword stores to the word-only data RAM use a read-modify-write sequence. Sits between the execute/memory-stage control and the synchronous data RAM port.

## Interface
- ADDR_W, 32, byte-address width; RAM address is word-aligned within it.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  block idle, request accepted when req_valid && req_ready
- req_addr  in  ADDR_W  byte address of store
- req_data  in  32  source register value; sub-word stores use low bits
- req_mask  in  2  size: mask[1]=1 word (11 also word); 01 halfword; 00 byte
- ram_addr  out  ADDR_W  word address, {req_addr[ADDR_W-1:2], 2'b00}
- ram_rd_en  out  1  RAM read strobe; ram_rd_data valid the following cycle
- ram_rd_data  in  32  RAM read data
- ram_wr_en  out  1  RAM write strobe
- ram_wr_data  out  32  RAM write data
- ram_be  out  4  byte enables (see Configuration)
- done  out  1  one-cycle pulse, store committed this cycle
- misaligned  out  1  one-cycle pulse, request rejected for alignment

## Operation
- States: IDLE, READ, MERGE, WRITE, ERR. Moore outputs decoded from state and latched request registers.
- IDLE: req_ready=1. On handshake, latch addr/data/mask.
  - Word, addr[1:0]≠0 → ERR.
  - Halfword, addr[0]=1 → ERR.
  - Otherwise word → WRITE.
  - Otherwise byte/halfword → READ.
- READ: ram_rd_en=1, ram_addr driven. → MERGE.
- MERGE: capture ram_rd_data into a merge register, then replace one lane:
  - Byte: lane = addr[1:0]; bits [8·lane+7 : 8·lane] ← data[7:0].
  - Halfword: bits [16·addr[1]+15 : 16·addr[1]] ← data[15:0].
  - Little-endian lane order: byte address 0 maps to bits 7:0, identical to the load path.
  - → WRITE.
- WRITE: ram_wr_en=1, done=1.
  - ram_wr_data = data for a word store, merge register for byte/halfword.
  - ram_be=4'b1111 in the base build.
  - → IDLE.
- ERR: misaligned=1. No RAM strobes, no done. → IDLE.
- req_valid while not IDLE: ignored; req_ready=0 and latched values unchanged.
- Outputs outside their asserting state: strobes, done, misaligned and ram_be are 0. ram_addr and ram_wr_data hold their last latched value.
- Reset values: state IDLE, req_ready=1, all strobes/pulses 0, ram_addr=0, ram_wr_data=0, ram_be=0, latched registers 0.
- Reset mid-operation, including in READ or MERGE: return to IDLE immediately. The in-flight store is dropped and no write is issued.

## Timing
- Cycle 0 is the handshake cycle.
- Word store: WRITE/done in cycle 1. req_ready again in cycle 2. Throughput 1 store per 2 cycles.
- Byte/halfword store:
  - ram_rd_en in cycle 1.
  - ram_rd_data sampled at the end of cycle 2 (MERGE).
  - ram_wr_en/done in cycle 3.
  - req_ready in cycle 4.
- Misaligned: misaligned pulse in cycle 1, req_ready in cycle 2.
- RAM read latency fixed at exactly 1 cycle. No RAM back-pressure.

## Configuration
- STORE_BYTE_ENABLE_EN defined (RAM with byte-write support):
  - READ and MERGE are never entered; all aligned stores go IDLE → WRITE with done in cycle 1.
  - ram_wr_data replicates the source: byte {4{data[7:0]}}, halfword {2{data[15:0]}}.
  - ram_be: byte = 1<<addr[1:0]; halfword = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
  - ram_rd_en is never asserted.
- Macro undefined:
  - Read-modify-write as described above.
  - ram_be=4'b1111 during WRITE and 0 otherwise.
  - ram_rd_data is used.
- Alignment checks are identical in both builds.

## Test plan
- Word store, addr 0x100, data 0xDEADBEEF, mask 10 → cycle 1: wr_en=1, ram_addr=0x100, wr_data=0xDEADBEEF, done=1, rd_en never asserted. req_ready=1 in cycle 2.
- Byte store, addr 0x103, data 0x000000AB, RAM word 0x11223344 → cycle 1: rd_en, ram_addr=0x100. Cycle 3: wr_en, wr_data=0xAB223344, done.
- Halfword store, addr 0x102, data 0x1234CAFE, RAM word 0x11223344 → cycle 3: wr_data=0xCAFE3344. Back-to-back request held during cycles 1–3 is accepted only in cycle 4.
- Halfword at 0x101, then word at 0x102 → each yields misaligned=1 in cycle 1, with no rd_en/wr_en/done.
- Byte store at 0x100, rst_n low in cycle 2 (MERGE) → all strobes 0 at once and no write issued. After release, a word store at 0x200 completes normally.
- STORE_BYTE_ENABLE_EN build: byte store, addr 0x101, data 0x55 → cycle 1: wr_en, ram_be=4'b0010, wr_data=0x55555555, done, no rd_en.
